// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if
// Bundles the two buses the boot loader talks on:
//   host byte stream : byte_valid, byte_data, byte_last (to loader),
//                      byte_ready (from loader)
//   system mem port  : mem_addr, mem_din, mem_we, own_mem (from loader),
//                      mem_dout (to loader, one clk after its address)
// The slave modport is the loader's view; master is the host/memory side.
// ---------------------------------------------------------------------------
interface prog_loader_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  byte_valid;
    logic [DATA_WIDTH-1:0] byte_data;
    logic                  byte_last;
    logic                  byte_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic                  own_mem;

    modport master (
        output byte_valid, byte_data, byte_last, mem_dout,
        input  byte_ready, mem_addr, mem_din, mem_we, own_mem
    );

    modport slave (
        input  byte_valid, byte_data, byte_last, mem_dout,
        output byte_ready, mem_addr, mem_din, mem_we, own_mem
    );
endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Boot-time program loader. While the CPU core is held in reset it takes the
// system mem port, streams host bytes into memory starting at load_base,
// reads the region back, compares the readback sum/count with what was
// written, and on success releases the CPU and pulses trigger_program.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   start, load_base  begin a load (IDLE/DONE/ERROR only), first address
//   bus (slave)       host byte stream + system mem port, see prog_loader_if
//   cpu_reset_n       CPU core reset, low until a load verifies
//   trigger_program   one-cycle kick to the fetcher
//   busy/done/error   status; err_code 01 = address overflow,
//                     10 = checksum/count mismatch
//   checksum          mod-2^DATA_WIDTH sum of written bytes
//   byte_count        bytes written in the current/last load
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    prog_loader_if.slave          bus,
    output logic                  cpu_reset_n,
    output logic                  trigger_program,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic [ADDR_WIDTH-1:0] byte_count
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_VERIFY,
        ST_CHECK,
        ST_RELEASE,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_cnt;
    logic [ADDR_WIDTH-1:0] vcount;
    logic [DATA_WIDTH-1:0] vsum;
    logic                  rd_pending;

    logic wr_over;
    logic last_read;

    // An accepted byte aimed past the top of memory aborts the load instead
    // of wrapping round to address 0.
    assign wr_over   = (wr_ptr > LAST_ADDR);
    // The final readback word arrives one cycle after the last address went
    // out, i.e. once every address has been issued and a read is pending.
    assign last_read = rd_pending && (rd_cnt == byte_count);

    // Mem port drive. Writes must land in the same cycle the byte is
    // offered, so the write strobe and address are decoded combinationally
    // from the registered state rather than registered themselves.
    always_comb begin
        bus.byte_ready = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_din    = '0;
        case (state)
            ST_WRITE: begin
                bus.byte_ready = 1'b1;
                bus.mem_addr   = wr_ptr;
                bus.mem_din    = bus.byte_data;
                bus.mem_we     = bus.byte_valid && !wr_over;
            end
            ST_VERIFY: begin
                bus.mem_addr = rd_ptr;
            end
            default: begin
            end
        endcase
    end

    // Loader sequencer with registered status outputs. The verify phase is a
    // one-deep read pipeline: an address is issued per cycle while rd_cnt
    // trails byte_count, and the data for the previous address is summed
    // whenever rd_pending is set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            base            <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            rd_cnt          <= '0;
            vcount          <= '0;
            vsum            <= '0;
            rd_pending      <= 1'b0;
            bus.own_mem     <= 1'b0;
            cpu_reset_n     <= 1'b0;
            trigger_program <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            err_code        <= 2'b00;
            checksum        <= '0;
            byte_count      <= '0;
        end else begin
            trigger_program <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state       <= ST_WRITE;
                        base        <= load_base;
                        wr_ptr      <= load_base;
                        checksum    <= '0;
                        byte_count  <= '0;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        err_code    <= 2'b00;
                        cpu_reset_n <= 1'b0;
                        bus.own_mem <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (bus.byte_valid) begin
                        if (wr_over) begin
                            state       <= ST_ERROR;
                            error       <= 1'b1;
                            err_code    <= 2'b01;
                            busy        <= 1'b0;
                            bus.own_mem <= 1'b0;
                        end else begin
                            wr_ptr     <= wr_ptr + ADDR_WIDTH'(1);
                            byte_count <= byte_count + ADDR_WIDTH'(1);
                            checksum   <= checksum + bus.byte_data;
                            if (bus.byte_last) begin
                                state      <= ST_VERIFY;
                                rd_ptr     <= base;
                                rd_cnt     <= '0;
                                rd_pending <= 1'b0;
                                vsum       <= '0;
                                vcount     <= '0;
                            end
                        end
                    end
                end
                ST_VERIFY: begin
                    if (rd_cnt != byte_count) begin
                        rd_ptr     <= rd_ptr + ADDR_WIDTH'(1);
                        rd_cnt     <= rd_cnt + ADDR_WIDTH'(1);
                        rd_pending <= 1'b1;
                    end else begin
                        rd_pending <= 1'b0;
                    end
                    if (rd_pending) begin
                        vsum   <= vsum + bus.mem_dout;
                        vcount <= vcount + ADDR_WIDTH'(1);
                    end
                    if (last_read) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (vsum == checksum && vcount == byte_count) begin
                        state           <= ST_RELEASE;
                        bus.own_mem     <= 1'b0;
                        cpu_reset_n     <= 1'b1;
                        trigger_program <= 1'b1;
                        busy            <= 1'b0;
                    end else begin
                        state       <= ST_ERROR;
                        error       <= 1'b1;
                        err_code    <= 2'b10;
                        busy        <= 1'b0;
                        bus.own_mem <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Drives prog_loader with directed boot loads and randomized loads, keeping
// its own memory model on the mem port and predicting outcomes from the
// load description (addresses, byte list, corrupted readback address).
// ---------------------------------------------------------------------------
module tb_prog_loader;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 1024;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] load_base;
    logic          cpu_reset_n;
    logic          trigger_program;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;
    logic [DW-1:0] checksum;
    logic [AW-1:0] byte_count;

    prog_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .load_base       (load_base),
        .bus             (bus.slave),
        .cpu_reset_n     (cpu_reset_n),
        .trigger_program (trigger_program),
        .busy            (busy),
        .done            (done),
        .error           (error),
        .err_code        (err_code),
        .checksum        (checksum),
        .byte_count      (byte_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int trig_total  = 0;
    int trig_cyc    = 0;
    logic trig_rst  = 1'b0;
    logic trig_own  = 1'b0;
    int first_cyc   = 0;
    int last_cyc    = 0;

    logic [7:0]    mem_model [DEPTH];
    logic          scrub;
    logic [7:0]    scrub_val;
    logic          corrupt_en;
    logic [AW-1:0] corrupt_addr;
    logic [7:0]    load_bytes [$];

    // Free-running cycle counter for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Memory behind the mem port: synchronous write, one-cycle read latency,
    // optional bit-0 flip on readback of one address to fake a bad cell.
    always @(posedge clk) begin
        if (scrub) begin
            for (int i = 0; i < DEPTH; i++) mem_model[i] <= scrub_val;
        end else if (bus.own_mem && bus.mem_we && bus.mem_addr < AW'(DEPTH)) begin
            mem_model[bus.mem_addr[9:0]] <= bus.mem_din;
        end
        if (bus.own_mem && bus.mem_addr < AW'(DEPTH))
            bus.mem_dout <= mem_model[bus.mem_addr[9:0]]
                            ^ {7'b0, (corrupt_en && bus.mem_addr == corrupt_addr)};
        else
            bus.mem_dout <= '0;
    end

    // Records every cycle the fetcher kick is high, plus the CPU reset and
    // mem ownership seen alongside it.
    always @(negedge clk) begin
        if (trigger_program) begin
            trig_total <= trig_total + 1;
            trig_cyc   <= cyc;
            trig_rst   <= cpu_reset_n;
            trig_own   <= bus.own_mem;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
        checkOutput({tag, "_we"},    32'(bus.mem_we), 32'd0);
        checkOutput({tag, "_addr"},  32'(bus.mem_addr), 32'd0);
        checkOutput({tag, "_din"},   32'(bus.mem_din), 32'd0);
        checkOutput({tag, "_own"},   32'(bus.own_mem), 32'd0);
        checkOutput({tag, "_cpurst"},32'(cpu_reset_n), 32'd0);
        checkOutput({tag, "_trig"},  32'(trigger_program), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy), 32'd0);
        checkOutput({tag, "_done"},  32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_ecode"}, 32'(err_code), 32'd0);
        checkOutput({tag, "_csum"},  32'(checksum), 32'd0);
        checkOutput({tag, "_count"}, 32'(byte_count), 32'd0);
    endtask

    // One complete load of load_bytes at base. The expected outcome comes
    // from the load description: bytes whose address is past the top of
    // memory stop the load, otherwise a corrupted address in the region
    // fails verification, otherwise the CPU is released.
    task automatic applyStimulus(input logic [AW-1:0] base, input int min_gap,
                                 input int max_gap, input bit hold_start,
                                 input bit abort_in_verify);
        int n       = load_bytes.size();
        int written = 0;
        int n_send;
        int exp_sum = 0;
        int exp_code;
        int trig0;
        bit ovf     = 0;
        bit bad     = 0;
        bit ok;

        for (int i = 0; i < n; i++) begin
            if (int'(base) + i > DEPTH - 1) begin
                ovf = 1;
                break;
            end
            exp_sum = (exp_sum + int'(load_bytes[i])) % 256;
            written++;
        end
        n_send = ovf ? written + 1 : n;
        if (!ovf && corrupt_en && int'(corrupt_addr) >= int'(base)
            && int'(corrupt_addr) < int'(base) + written)
            bad = 1;
        ok       = !ovf && !bad;
        exp_code = ovf ? 1 : (bad ? 2 : 0);

        @(negedge clk);
        scrub     = 1'b1;
        scrub_val = 8'($urandom);
        @(negedge clk);
        scrub     = 1'b0;
        trig0     = trig_total;
        start     = 1'b1;
        load_base = base;
        @(negedge clk);
        if (!hold_start) start = 1'b0;

        for (int i = 0; i < n_send; i++) begin
            int g = (i == 0) ? 0 : int'($urandom_range(max_gap, min_gap));
            for (int k = 0; k < g; k++) begin
                bus.byte_valid = 1'b0;
                bus.byte_data  = 8'($urandom);
                bus.byte_last  = 1'b0;
                #1;
                checkOutput("gap_we", 32'(bus.mem_we), 32'd0);
                @(negedge clk);
            end
            bus.byte_valid = 1'b1;
            bus.byte_data  = load_bytes[i];
            bus.byte_last  = (i == n - 1);
            if (i == n_send - 1) start = 1'b0;
            #1;
            if (i == 0) first_cyc = cyc;
            last_cyc = cyc;
            checkOutput("wr_ready", 32'(bus.byte_ready), 32'd1);
            checkOutput("wr_own", 32'(bus.own_mem), 32'd1);
            checkOutput("wr_busy", 32'(busy), 32'd1);
            checkOutput("wr_we", 32'(bus.mem_we), 32'(i < written));
            if (i < written) checkOutput("wr_addr", 32'(bus.mem_addr), 32'(int'(base) + i));
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        bus.byte_last  = 1'b0;

        if (abort_in_verify) begin
            @(negedge clk);
            reset_n = 1'b0;
            @(negedge clk);
            checkResetValues("midrst");
            reset_n = 1'b1;
            return;
        end

        for (int k = 0; k < 4 * n + 40 && !(done || error); k++) @(negedge clk);
        if (!(done || error)) begin
            checkOutput("finish_timeout", 32'd0, 32'd1);
            return;
        end

        checkOutput("done", 32'(done), 32'(ok));
        checkOutput("error", 32'(error), 32'(!ok));
        checkOutput("err_code", 32'(err_code), 32'(exp_code));
        checkOutput("checksum", 32'(checksum), 32'(exp_sum));
        checkOutput("byte_count", 32'(byte_count), 32'(written));
        checkOutput("cpu_reset_n", 32'(cpu_reset_n), 32'(ok));
        checkOutput("own_after", 32'(bus.own_mem), 32'd0);
        checkOutput("busy_after", 32'(busy), 32'd0);
        checkOutput("trig_cycles", 32'(trig_total - trig0), 32'(ok));
        if (ok) begin
            checkOutput("trig_cpurst", 32'(trig_rst), 32'd1);
            checkOutput("trig_own", 32'(trig_own), 32'd0);
            checkOutput("release_lat", 32'(trig_cyc - last_cyc), 32'(n + 3));
        end
        for (int i = 0; i < written; i++)
            checkOutput("mem", 32'(mem_model[int'(base) + i]), 32'(load_bytes[i]));

        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'($urandom);
        #1;
        checkOutput("idle_we", 32'(bus.mem_we), 32'd0);
        checkOutput("idle_ready", 32'(bus.byte_ready), 32'd0);
        @(negedge clk);
        bus.byte_valid = 1'b0;
        checkOutput("status_hold", 32'({done, error}), 32'({ok, !ok}));
    endtask

    initial begin
        reset_n        = 1'b0;
        start          = 1'b0;
        load_base      = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        bus.byte_last  = 1'b0;
        scrub          = 1'b0;
        scrub_val      = '0;
        corrupt_en     = 1'b0;
        corrupt_addr   = '0;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset_n = 1'b1;

        $display("[TB] basic load");
        load_bytes = '{8'hA9, 8'h05, 8'h8D};
        applyStimulus(16'h0100, 0, 0, 1'b0, 1'b0);
        checkOutput("basic_csum", 32'(checksum), 32'h3B);
        checkOutput("basic_lat", 32'(trig_cyc - first_cyc), 32'd8);

        $display("[TB] backpressure gaps");
        applyStimulus(16'h0100, 2, 2, 1'b0, 1'b0);
        checkOutput("gaps_csum", 32'(checksum), 32'h3B);

        $display("[TB] checksum wrap");
        load_bytes = '{8'hFF, 8'hFF, 8'h03};
        applyStimulus(16'h0000, 0, 0, 1'b0, 1'b0);
        checkOutput("wrap_csum", 32'(checksum), 32'h01);
        checkOutput("wrap_done", 32'(done), 32'd1);

        $display("[TB] overflow");
        load_bytes = '{8'h11, 8'h22, 8'h33};
        applyStimulus(16'h03FE, 0, 0, 1'b0, 1'b0);
        checkOutput("ovf_code", 32'(err_code), 32'd1);
        checkOutput("ovf_3ff", 32'(mem_model[16'h03FF]), 32'h22);

        $display("[TB] verify fail");
        corrupt_en   = 1'b1;
        corrupt_addr = 16'h0101;
        load_bytes   = '{8'hA9, 8'h05, 8'h8D};
        applyStimulus(16'h0100, 0, 0, 1'b0, 1'b0);
        checkOutput("vfail_code", 32'(err_code), 32'd2);
        corrupt_en = 1'b0;

        $display("[TB] reset mid-verify then restart");
        applyStimulus(16'h0100, 0, 0, 1'b0, 1'b1);
        load_bytes = '{8'hEA};
        applyStimulus(16'h0200, 0, 0, 1'b0, 1'b0);
        checkOutput("restart_csum", 32'(checksum), 32'hEA);
        checkOutput("restart_done", 32'(done), 32'd1);

        $display("[TB] randomized loads");
        for (int t = 0; t < 30; t++) begin
            int n = int'($urandom_range(16, 1));
            logic [AW-1:0] b;
            load_bytes.delete();
            for (int i = 0; i < n; i++) load_bytes.push_back(8'($urandom));
            if ($urandom_range(3, 0) == 0)
                b = AW'(DEPTH - int'($urandom_range(n + 2, 1)));
            else
                b = AW'($urandom_range(DEPTH - n, 0));
            corrupt_en   = ($urandom_range(4, 0) == 0);
            corrupt_addr = AW'(int'(b) + int'($urandom_range(n - 1, 0)));
            applyStimulus(b, 0, 2, 1'($urandom_range(1, 0)), 1'b0);
        end
        corrupt_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader that sits upstream of the fetcher/decoder pipeline.
- While the CPU core is held in reset, it takes ownership of the system mem port and streams program bytes from a host byte interface into memory. It then reads the written region back and checks it against a running checksum.
- On a match it releases CPU reset and pulses trigger_program so the fetcher starts at the loaded code.
- This replaces the manual_mem / trigger_program sequencing previously done by hand.

Parameters:
- ADDR_WIDTH, 16, mem address width.
- DATA_WIDTH, 8, mem/byte data width.
- MEM_DEPTH, 1024, number of mem locations; highest legal address is MEM_DEPTH-1.

Ports:
- clk  in  1  system clock (phi2 domain).
- reset_n  in  1  synchronous active-low reset.
- start  in  1  level-sampled; starts a load when in IDLE, DONE or ERROR.
- load_base  in  ADDR_WIDTH  first mem address of the load; sampled when start is accepted.
- byte_valid  in  1  host byte present.
- byte_data  in  DATA_WIDTH  host byte.
- byte_last  in  1  marks the final byte of the load; qualified by byte_valid.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_addr  out  ADDR_WIDTH  mem address.
- mem_din  out  DATA_WIDTH  mem write data.
- mem_we  out  1  mem write enable.
- mem_dout  in  DATA_WIDTH  mem read data; valid one clk after its address is presented.
- own_mem  out  1  mux select; 1 routes the loader's addr/din/we to mem instead of the fetcher's.
- cpu_reset_n  out  1  reset to the CPU core (regs, fetcher, decoder, ALU).
- trigger_program  out  1  one-cycle pulse to the fetcher get_next.
- busy  out  1  load or verify in progress.
- done  out  1  last load verified OK.
- error  out  1  last load failed.
- err_code  out  2  01 = address overflow, 10 = checksum/count mismatch.
- checksum  out  DATA_WIDTH  mod-2^DATA_WIDTH sum of written bytes.
- byte_count  out  ADDR_WIDTH  bytes written in the current/last load.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - State goes to IDLE.
  - Outputs: byte_ready=0, mem_we=0, mem_addr=0, mem_din=0, own_mem=0, cpu_reset_n=0, trigger_program=0, busy=0, done=0, error=0, err_code=0, checksum=0, byte_count=0.
  - The CPU stays in reset until the first successful load.
- States: IDLE, WRITE, VERIFY, CHECK, RELEASE, DONE, ERROR.
- IDLE/DONE/ERROR with start=1:
  - Go to WRITE.
  - Latch wr_ptr=load_base; clear checksum, byte_count, done, error, err_code.
  - Drive cpu_reset_n=0 and own_mem=1 from the next cycle.
  - start is ignored in every other state.
- WRITE:
  - byte_ready=1, busy=1, own_mem=1.
  - On byte_valid & byte_ready, in the same cycle: mem_we=1, mem_addr=wr_ptr, mem_din=byte_data. At the clk edge: wr_ptr++, byte_count++, checksum+=byte_data (wraps mod 256).
  - If byte_last is set on an accepted byte, go to VERIFY with rd_ptr=load_base.
  - No byte_valid: mem_we=0 and the state holds indefinitely.
  - A load is at least 1 byte.
- Overflow in WRITE:
  - An accepted byte with wr_ptr > MEM_DEPTH-1 is not written (mem_we=0).
  - Go to ERROR with err_code=01.
  - Address MEM_DEPTH-1 itself is writable. No wrap to 0.
- VERIFY:
  - mem_we=0, byte_ready=0.
  - One address per cycle: mem_addr=rd_ptr, from load_base to load_base+byte_count-1.
  - Each mem_dout is summed into vsum and counted in vcount one cycle after its address (read-pending flag, 1-cycle pipeline).
  - After the last read data is accumulated, go to CHECK.
  - Total VERIFY length is byte_count+1 cycles.
- CHECK (1 cycle):
  - vsum==checksum and vcount==byte_count: go to RELEASE.
  - Otherwise go to ERROR with err_code=10.
- RELEASE (1 cycle): own_mem=0, cpu_reset_n=1, trigger_program=1. Then go to DONE.
- DONE: done=1, cpu_reset_n=1, own_mem=0, busy=0.
- ERROR: error=1, cpu_reset_n=0, own_mem=0, busy=0. Held until start or reset.
- Outputs:
  - checksum and byte_count remain readable in DONE and ERROR.
  - trigger_program is never high outside RELEASE.
- Reset mid-load (WRITE or VERIFY): abort at the edge to IDLE with all reset values. Memory contents already written are left as is.
- byte_valid in non-WRITE states: ignored, byte_ready=0, no write.

Test Plan:
- Basic load: reset, start with load_base=0x0100, bytes A9,05,8D(last) on consecutive cycles. Required response:
  - mem holds A9/05/8D at 0x0100-0x0102.
  - checksum=0x3B, byte_count=3.
  - RELEASE occurs 3+4+1 cycles after the first byte.
  - trigger_program high for exactly 1 cycle with cpu_reset_n=1; done=1.
- Backpressure gaps: same bytes with byte_valid low for 2 cycles between each. Required response: the same memory contents and checksum; mem_we low during the gaps.
- Checksum wrap: load FF,FF,03 at 0x0000. Required response: checksum=0x01, done=1.
- Overflow: load_base=0x03FE, 3 bytes. Required response:
  - 0x03FE and 0x03FF written.
  - Third byte not written; error=1, err_code=01.
  - cpu_reset_n=0, no trigger pulse.
- Verify fail: bench mem model flips bit 0 on readback of 0x0101 during the basic load. Required response: error=1, err_code=10, cpu_reset_n stays 0.
- Reset mid-VERIFY, then restart: reset_n=0 during VERIFY. Required response: all outputs return to reset values next cycle. A fresh start with a 1-byte load 0xEA then gives done=1, checksum=0xEA.
